// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and restoring
// divider, one bit per cycle, with a separate sign-correction cycle before done.
module mul_div_unit #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WIDTH - 1);
   localparam logic [WIDTH-1:0]     MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [2:0]           op_reg;
   logic                 sgn_a_reg;
   logic                 sgn_b_reg;
   logic [WIDTH-1:0]     opa_reg;
   logic [WIDTH-1:0]     opb_reg;
   logic [2*WIDTH-1:0]   prod_reg;
   logic [WIDTH-1:0]     rem_reg;
   logic [WIDTH-1:0]     quo_reg;
   logic [CNT_WIDTH-1:0] cnt_reg;
   logic                 early_reg;
   logic [WIDTH-1:0]     early_val_reg;
   logic [WIDTH-1:0]     out_reg;

   logic                 accept;
   logic                 sgn_a_in;
   logic                 sgn_b_in;
   logic [WIDTH-1:0]     mag_a_in;
   logic [WIDTH-1:0]     mag_b_in;
   logic                 div_zero;
   logic                 div_ovf;
   logic                 early_in;
   logic [WIDTH-1:0]     early_val_in;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   prod_step;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic [WIDTH-1:0]     rem_step;
   logic [WIDTH-1:0]     quo_step;

   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     rem_fix;
   logic [WIDTH-1:0]     result;

   assign accept = (state == IDLE) && start;

   // Operand decode on the raw inputs; only consumed in the accept cycle.
   always_comb begin
      sgn_a_in = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM))
                 && inA[WIDTH-1];
      sgn_b_in = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) && inB[WIDTH-1];
      mag_a_in = sgn_a_in ? -inA : inA;
      mag_b_in = sgn_b_in ? -inB : inB;
      div_zero = op[2] && (inB == '0);
      div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (inA == MOST_NEG) && (inB == '1);
      early_in = div_zero || div_ovf;
      early_val_in = '0;
      if (div_zero) begin
         early_val_in = op[1] ? inA : '1;
      end else if (div_ovf) begin
         early_val_in = op[1] ? '0 : inA;
      end
   end

   // One iteration of each algorithm; op_reg[2] picks which one is applied.
   always_comb begin
      mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, opa_reg} : '0);
      prod_step = {mul_sum, prod_reg[WIDTH-1:1]};
      div_shift = {rem_reg, quo_reg[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_reg};
      if (!div_diff[WIDTH]) begin
         rem_step = div_diff[WIDTH-1:0];
         quo_step = {quo_reg[WIDTH-2:0], 1'b1};
      end else begin
         rem_step = div_shift[WIDTH-1:0];
         quo_step = {quo_reg[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction: remainder follows the dividend, the rest follow sign parity.
   always_comb begin
      prod_fix = (sgn_a_reg ^ sgn_b_reg) ? -prod_reg : prod_reg;
      quo_fix  = (sgn_a_reg ^ sgn_b_reg) ? -quo_reg  : quo_reg;
      rem_fix  = sgn_a_reg ? -rem_reg : rem_reg;
      result   = '0;
      if (early_reg) begin
         result = early_val_reg;
      end else begin
         case (op_reg)
            OP_MUL:                        result = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               result = quo_fix;
            OP_REM, OP_REMU:               result = rem_fix;
            default:                       result = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = early_in ? FIX : CALC;
         CALC:    if (cnt_reg == CNT_LAST) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         op_reg        <= '0;
         sgn_a_reg     <= 1'b0;
         sgn_b_reg     <= 1'b0;
         opa_reg       <= '0;
         opb_reg       <= '0;
         prod_reg      <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         cnt_reg       <= '0;
         early_reg     <= 1'b0;
         early_val_reg <= '0;
         out_reg       <= '0;
      end else begin
         if (accept) begin
            op_reg        <= op;
            sgn_a_reg     <= sgn_a_in;
            sgn_b_reg     <= sgn_b_in;
            opa_reg       <= mag_a_in;
            opb_reg       <= mag_b_in;
            prod_reg      <= {{WIDTH{1'b0}}, mag_b_in};
            rem_reg       <= '0;
            quo_reg       <= mag_a_in;
            cnt_reg       <= '0;
            early_reg     <= early_in;
            early_val_reg <= early_val_in;
         end else if (state == CALC) begin
            if (op_reg[2]) begin
               rem_reg <= rem_step;
               quo_reg <= quo_step;
            end else begin
               prod_reg <= prod_step;
            end
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
         end else if (state == FIX) begin
            out_reg <= result;
         end
      end
   end

   assign out = out_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected results go into a scoreboard queue
// when an operation is issued and are popped when done is observed.
module tb_mul_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rstN = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] inA = '0;
   logic [W-1:0] inB = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] out;

   int total = 0;
   int bad = 0;
   logic [W-1:0] exp_q[$];

   mul_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rstN  (rstN),
      .start (start),
      .op    (op),
      .inA   (inA),
      .inB   (inB),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
      end
   endtask

   // Issue one operation, optionally poke a second start at cycle `poke`, then
   // check latency, busy length, result and that no further done appears.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] want,
                         input int lat, input int poke);
      int cyc;
      int busy_cnt;
      int stray;
      bit seen;
      logic [W-1:0] e;
      @(negedge clk);
      op = o; inA = a; inB = b; start = 1'b1;
      exp_q.push_back(want);
      @(posedge clk); #1;
      start = 1'b0;
      op = 3'($urandom); inA = $urandom; inB = $urandom;
      cyc = 1; busy_cnt = 0; seen = 1'b0;
      while (cyc <= 60) begin
         if (cyc == poke) begin
            start = 1'b1; op = 3'd5; inA = 32'd100; inB = 32'd7;
         end
         if (cyc == poke + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, ".done_seen"}, 64'(seen), 64'd1);
      check({tag, ".latency"}, 64'(cyc), 64'(lat));
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(lat));
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s.scoreboard: observed=empty expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, ".out"}, 64'(out), 64'(e));
      end
      $display("op=%0d a=0x%08h b=0x%08h out=0x%08h cycles=%0d", o, a, b, out, cyc);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, ".idle_after"}, 64'({busy, done}), 64'd0);
      stray = 0;
      for (int i = 0; i < ((poke > 0) ? 40 : 3); i++) begin
         @(posedge clk); #1;
         if (done || busy) stray++;
      end
      check({tag, ".no_extra_done"}, 64'(stray), 64'd0);
   endtask

   initial begin
      int stray;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      check("reset.hold", 64'({busy, done, out}), 64'd0);
      @(negedge clk);
      rstN = 1'b1;
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) stray++;
      end
      check("reset.no_done", 64'(stray), 64'd0);
      check("reset.out", 64'(out), 64'd0);

      // Multiplies
      run_op("mul_ones",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, -1);
      run_op("mulhu_ones",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, -1);
      run_op("mulh_neg",    3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, -1);
      run_op("mulhsu_neg",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, -1);
      run_op("mul_small",   3'd0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 34, -1);

      // Divides
      run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, -1);
      run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, -1);
      run_op("divu_100_7",  3'd5, 32'd100,       32'd7,         32'd14,        34, -1);
      run_op("remu_100_7",  3'd7, 32'd100,       32'd7,         32'd2,         34, -1);
      run_op("div_20_m3",   3'd4, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, -1);
      run_op("rem_20_m3",   3'd6, 32'd20,        32'hFFFF_FFFD, 32'd2,         34, -1);

      // Early-out cases
      run_op("divu_by0",    3'd5, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 2, -1);
      run_op("rem_by0",     3'd6, 32'd5,         32'd0,         32'd5,         2, -1);
      run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, -1);
      run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2, -1);

      // Start while busy, and start coinciding with the DONE cycle
      run_op("div_poke10",  3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 10);
      run_op("divu_poke34", 3'd5, 32'd100,       32'd7,         32'd14,        34, 34);

      // Reset mid-operation
      @(negedge clk);
      op = 3'd4; inA = 32'hFFFF_FFF9; inB = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check("midrst.busy_before", 64'(busy), 64'd1);
      rstN = 1'b0;
      #1;
      check("midrst.outputs", 64'({busy, done, out}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) stray++;
      end
      check("midrst.no_done", 64'(stray), 64'd0);
      check("midrst.out", 64'(out), 64'd0);
      $display("op=4 a=0xfffffff9 b=0x00000002 aborted by reset out=0x%08h", out);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
